// File: rtl/de_sel_pkg.sv
// Shared constants and state encoding for the de_selector14 sequencer.
// Imported by the arbiter and the sequencer top.
package de_sel_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Round-robin picker: first set bit of elig searching upward
// from last+1, wrapping modulo 4.
module rr_pick4
  import de_sel_pkg::*;
(
  input  logic [NCH-1:0]   elig,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] pick,
  output logic             found
);

  logic [SEL_W-1:0] w_idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    w_idx = '0;
    for (int i = 1; i <= NCH; i++) begin
      // 2-bit add wraps naturally; i=4 lands back on last
      w_idx = last + SEL_W'(i);
      if (!found && elig[w_idx]) begin
        pick  = w_idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/de_selector14_sched.sv
// Burst/round-robin sequencer driving the select and data
// inputs of the de_selector14 1-to-4 demux.
module de_selector14_sched
  import de_sel_pkg::*;
#(
  parameter int BURST_LEN  = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic           iCLK,
  input  logic           iRST_N,
  input  logic           iValid,
  input  logic           iData,
  input  logic [NCH-1:0] iReady,
  input  logic [NCH-1:0] iEn,
  output logic           oAccept,
  output logic           oS1,
  output logic           oS0,
  output logic           oC,
  output logic [NCH-1:0] oGrant,
  output logic           oBusy
);

  localparam logic [CNT_W-1:0] LAST_BEAT =
    CNT_W'(BURST_LEN - 1);
  localparam logic [2:0] GAP_LAST =
    3'(GAP_CYCLES - 1);
  localparam state_t ST_END =
    (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  state_t           r_state;
  state_t           w_nxt;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_last;
  logic [SEL_W-1:0] w_pick;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_gcnt;
  logic [NCH-1:0]   r_grant;
  logic [NCH-1:0]   w_elig;
  logic             r_c;
  logic             r_busy;
  logic             w_found;
  logic             w_en_g;
  logic             w_beat;

  assign w_elig = iReady & iEn;
  assign w_en_g = iEn[r_sel];
  assign w_beat = iValid & oAccept;

  rr_pick4 u_pick (
    .elig  (w_elig),
    .last  (r_last),
    .pick  (w_pick),
    .found (w_found)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_busy  <= (w_nxt != ST_IDLE);
    end
  end

  // Losing the channel enable aborts the burst without a beat
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE:
        if (iValid && w_found) w_nxt = ST_XFER;
      ST_XFER:
        if ((w_beat && r_cnt == LAST_BEAT) || !w_en_g)
          w_nxt = ST_END;
      ST_GAP:
        if (r_gcnt == GAP_LAST) w_nxt = ST_IDLE;
      default:
        w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    oAccept = (r_state == ST_XFER)
            && iReady[r_sel] && w_en_g;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sel   <= '0;
      r_last  <= SEL_W'(NCH - 1);
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_grant <= '0;
      r_c     <= 1'b0;
    end else begin
      // oC is forced low on every non-beat edge, incl. select changes
      r_c    <= w_beat & iData;
      r_gcnt <= (r_state == ST_GAP) ? r_gcnt + 1'b1 : '0;
      if (r_state == ST_IDLE && w_nxt == ST_XFER) begin
        r_sel   <= w_pick;
        r_last  <= w_pick;
        r_grant <= NCH'(1) << w_pick;
        r_cnt   <= '0;
      end
      if (w_beat)
        r_cnt <= (r_cnt == LAST_BEAT) ? '0 : r_cnt + 1'b1;
      if (r_state != ST_IDLE && w_nxt == ST_IDLE)
        r_grant <= '0;
    end
  end

  assign oS1    = r_sel[1];
  assign oS0    = r_sel[0];
  assign oC     = r_c;
  assign oGrant = r_grant;
  assign oBusy  = r_busy;

endmodule

// File: tb/tb_de_selector14_sched.sv
// Bench for de_selector14_sched: three parameterisations share
// stimulus and are scored against a burst-level reference model.
module tb_de_selector14_sched;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b1;
  logic       iValid, iData;
  logic [3:0] iReady, iEn;
  logic [2:0] acc, s1, s0, c, busy;
  logic [3:0] grant [3];

  int n_chk = 0;
  int n_fail = 0;
  bit mon_on = 1'b0;

  localparam int BLK [3] = '{4, 2, 1};
  localparam int GPK [3] = '{1, 1, 0};

  // model: granted channel (-1 none), beats done, gap left
  int   m_ch [3];
  int   m_sel [3];
  int   m_last [3];
  int   m_done [3];
  int   m_gap [3];
  logic m_c [3];

  always #5 iCLK = ~iCLK;

  de_selector14_sched #(.BURST_LEN(4), .GAP_CYCLES(1)) u0 (
    .iCLK(iCLK), .iRST_N(iRST_N), .iValid(iValid),
    .iData(iData), .iReady(iReady), .iEn(iEn),
    .oAccept(acc[0]), .oS1(s1[0]), .oS0(s0[0]),
    .oC(c[0]), .oGrant(grant[0]), .oBusy(busy[0]));

  de_selector14_sched #(.BURST_LEN(2), .GAP_CYCLES(1)) u1 (
    .iCLK(iCLK), .iRST_N(iRST_N), .iValid(iValid),
    .iData(iData), .iReady(iReady), .iEn(iEn),
    .oAccept(acc[1]), .oS1(s1[1]), .oS0(s0[1]),
    .oC(c[1]), .oGrant(grant[1]), .oBusy(busy[1]));

  de_selector14_sched #(.BURST_LEN(1), .GAP_CYCLES(0)) u2 (
    .iCLK(iCLK), .iRST_N(iRST_N), .iValid(iValid),
    .iData(iData), .iReady(iReady), .iEn(iEn),
    .oAccept(acc[2]), .oS1(s1[2]), .oS0(s0[2]),
    .oC(c[2]), .oGrant(grant[2]), .oBusy(busy[2]));

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ch[k] = -1; m_sel[k] = 0; m_last[k] = 3;
      m_done[k] = 0; m_gap[k] = 0; m_c[k] = 1'b0;
    end
  endfunction

  function automatic logic macc(int k);
    if (m_ch[k] < 0 || m_gap[k] > 0) return 1'b0;
    return iReady[m_ch[k]] && iEn[m_ch[k]];
  endfunction

  function automatic logic [3:0] mgrant(int k);
    logic [3:0] one = 4'b0001;
    if (m_ch[k] < 0) return 4'b0000;
    return one << m_ch[k];
  endfunction

  function automatic void model_step(int k);
    logic [3:0] el = iReady & iEn;
    logic beat = iValid && macc(k);
    bit got = 1'b0;
    if (m_ch[k] < 0) begin
      m_c[k] = 1'b0;
      if (iValid && el != 4'b0)
        for (int i = 1; i <= 4; i++) begin
          int ch = (m_last[k] + i) % 4;
          if (!got && el[ch]) begin
            got = 1'b1; m_ch[k] = ch; m_sel[k] = ch;
            m_last[k] = ch; m_done[k] = 0;
          end
        end
    end else if (m_gap[k] > 0) begin
      m_c[k] = 1'b0;
      m_gap[k]--;
      if (m_gap[k] == 0) m_ch[k] = -1;
    end else begin
      m_c[k] = beat ? iData : 1'b0;
      if (beat) m_done[k]++;
      if ((beat && m_done[k] == BLK[k]) || !iEn[m_ch[k]]) begin
        m_done[k] = 0;
        if (GPK[k] > 0) m_gap[k] = GPK[k];
        else m_ch[k] = -1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge iCLK);
    if (iRST_N) for (int k = 0; k < 3; k++) model_step(k);
    #1;
  endtask

  task automatic do_reset();
    iRST_N = 1'b0;
    model_reset();
    @(negedge iCLK);
    #2 iRST_N = 1'b1;
  endtask

  // scoreboard: every output of every instance, every cycle
  always @(negedge iCLK) begin
    if (mon_on) begin
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (acc[k] !== macc(k)) begin
          n_fail++;
          $display("FAIL sb_accept[%0d] got %b want %b t=%0t",
                   k, acc[k], macc(k), $time);
        end
        n_chk++;
        if (grant[k] !== mgrant(k)) begin
          n_fail++;
          $display("FAIL sb_grant[%0d] got %b want %b t=%0t",
                   k, grant[k], mgrant(k), $time);
        end
        n_chk++;
        if ({s1[k], s0[k]} !== 2'(m_sel[k])) begin
          n_fail++;
          $display("FAIL sb_sel[%0d] got %b want %0d t=%0t",
                   k, {s1[k], s0[k]}, m_sel[k], $time);
        end
        n_chk++;
        if (c[k] !== m_c[k]) begin
          n_fail++;
          $display("FAIL sb_c[%0d] got %b want %b t=%0t",
                   k, c[k], m_c[k], $time);
        end
        n_chk++;
        if (busy[k] !== (m_ch[k] >= 0)) begin
          n_fail++;
          $display("FAIL sb_busy[%0d] got %b want %b t=%0t",
                   k, busy[k], (m_ch[k] >= 0), $time);
        end
      end
    end
  end

  task automatic test_reset();
    #1 iRST_N = 1'b0;
    model_reset();
    mon_on = 1'b1;
    #1;
    n_chk++;
    if ({grant[0], s1[0], s0[0], c[0], busy[0], acc[0]} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want 0",
               {grant[0], s1[0], s0[0], c[0], busy[0], acc[0]});
    end
    iValid = 1'b1; iReady = 4'hf; iEn = 4'hf;
    tick();
    n_chk++;
    if (grant[0] !== 4'b0 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold got %b/%b want 0000/0",
               grant[0], busy[0]);
    end
    iValid = 1'b0;
    @(negedge iCLK);
    #2 iRST_N = 1'b1;
  endtask

  task automatic test_single_channel();
    logic [3:0] dat = 4'b1101;
    iEn = 4'b1111; iReady = 4'b0100;
    iValid = 1'b1; iData = dat[0];
    tick();
    n_chk++;
    if (grant[0] !== 4'b0100 || {s1[0], s0[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_grant got %b sel %b want 0100 sel 10",
               grant[0], {s1[0], s0[0]});
    end
    for (int i = 0; i < 4; i++) begin
      iData = dat[i];
      @(negedge iCLK);
      n_chk++;
      if (acc[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL single_accept beat %0d got %b want 1",
                 i, acc[0]);
      end
      tick();
      n_chk++;
      if (c[0] !== dat[i]) begin
        n_fail++;
        $display("FAIL single_data beat %0d got %b want %b",
                 i, c[0], dat[i]);
      end
    end
    @(negedge iCLK);
    n_chk++;
    if (acc[0] !== 1'b0 || busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_gap acc %b busy %b want 0 1",
               acc[0], busy[0]);
    end
    tick();
    n_chk++;
    if (busy[0] !== 1'b0 || grant[0] !== 4'b0 || c[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle busy %b grant %b c %b want 0",
               busy[0], grant[0], c[0]);
    end
    iValid = 1'b0;
  endtask

  task automatic test_round_robin();
    int seen [$];
    logic [3:0] pg;
    logic [1:0] ps;
    do_reset();
    iEn = 4'hf; iReady = 4'hf; iValid = 1'b1;
    iData = 1'b1;
    pg = 4'b0;
    ps = {s1[1], s0[1]};
    for (int t = 0; t < 24; t++) begin
      tick();
      if (pg == 4'b0 && grant[1] != 4'b0)
        for (int b = 0; b < 4; b++)
          if (grant[1][b]) seen.push_back(b);
      if ({s1[1], s0[1]} != ps) begin
        n_chk++;
        if (c[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL rr_sel_while_c c got %b want 0", c[1]);
        end
      end
      pg = grant[1];
      ps = {s1[1], s0[1]};
    end
    for (int j = 0; j < 5; j++) begin
      n_chk++;
      if (j >= seen.size()) begin
        n_fail++;
        $display("FAIL rr_order grant %0d missing want %0d",
                 j, j % 4);
      end else if (seen[j] != j % 4) begin
        n_fail++;
        $display("FAIL rr_order grant %0d got %0d want %0d",
                 j, seen[j], j % 4);
      end
    end
    iValid = 1'b0;
  endtask

  task automatic test_stall();
    int n = 0;
    bit done = 1'b0;
    do_reset();
    iEn = 4'hf; iReady = 4'b0010; iValid = 1'b1;
    iData = 1'($urandom_range(0, 1));
    tick();
    n_chk++;
    if ({s1[0], s0[0]} !== 2'b01) begin
      n_fail++;
      $display("FAIL stall_sel got %b want 01", {s1[0], s0[0]});
    end
    tick();
    iReady = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK);
      n_chk++;
      if (acc[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_accept got %b want 0", acc[0]);
      end
      tick();
      n_chk++;
      if (c[0] !== 1'b0 || {s1[0], s0[0]} !== 2'b01) begin
        n_fail++;
        $display("FAIL stall_hold c %b sel %b want 0 01",
                 c[0], {s1[0], s0[0]});
      end
    end
    iReady = 4'b0010;
    for (int t = 0; t < 20 && !done; t++) begin
      iData = 1'($urandom_range(0, 1));
      @(negedge iCLK);
      if (acc[0]) n++;
      tick();
      if (grant[0] == 4'b0) done = 1'b1;
    end
    n_chk++;
    if (!done || n != 3) begin
      n_fail++;
      $display("FAIL stall_resume beats got %0d want 3 done %b",
               n, done);
    end
    iValid = 1'b0;
  endtask

  task automatic test_mask_abort();
    int n = 0;
    bit hit = 1'b0;
    do_reset();
    iEn = 4'b1010; iReady = 4'hf; iValid = 1'b1; iData = 1'b1;
    for (int t = 0; t < 30 && !hit; t++) begin
      tick();
      n_chk++;
      if (grant[0] & 4'b0101) begin
        n_fail++;
        $display("FAIL mask_grant got %b want only 0010/1000",
                 grant[0]);
      end
      if (grant[0] == 4'b1000) hit = 1'b1;
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL mask_ch3 timeout grant %b want 1000", grant[0]);
    end
    for (int t = 0; t < 10 && n < 2; t++) begin
      @(negedge iCLK);
      if (acc[0]) n++;
      tick();
    end
    iEn = 4'b0010;
    @(negedge iCLK);
    n_chk++;
    if (acc[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_accept got %b want 0", acc[0]);
    end
    tick();
    n_chk++;
    if (grant[0] !== 4'b1000 || busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_gap grant %b busy %b want 1000 1",
               grant[0], busy[0]);
    end
    tick();
    n_chk++;
    if (grant[0] !== 4'b0 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle grant %b busy %b want 0000 0",
               grant[0], busy[0]);
    end
    tick();
    n_chk++;
    if (grant[0] !== 4'b0010) begin
      n_fail++;
      $display("FAIL abort_next grant got %b want 0010", grant[0]);
    end
    iValid = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    iEn = 4'hf; iReady = 4'b0100; iValid = 1'b1; iData = 1'b1;
    tick();
    tick();
    n_chk++;
    if (busy[0] !== 1'b1 || c[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre busy %b c %b want 1 1",
               busy[0], c[0]);
    end
    #2 iRST_N = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if ({grant[0], s1[0], s0[0], c[0], busy[0]} !== 8'b0) begin
      n_fail++;
      $display("FAIL areset_now got %b want 0",
               {grant[0], s1[0], s0[0], c[0], busy[0]});
    end
    iReady = 4'hf;
    @(negedge iCLK);
    #2 iRST_N = 1'b1;
    tick();
    n_chk++;
    if (grant[0] !== 4'b0001) begin
      n_fail++;
      $display("FAIL areset_first grant got %b want 0001", grant[0]);
    end
    iValid = 1'b0;
  endtask

  task automatic test_zero_gap();
    logic [3:0] one = 4'b0001;
    do_reset();
    iEn = 4'hf; iReady = 4'hf; iValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iData = 1'($urandom_range(0, 1));
      tick();
      n_chk++;
      if (busy[2] !== (i % 2 == 0)) begin
        n_fail++;
        $display("FAIL zgap_busy cyc %0d got %b want %b",
                 i, busy[2], (i % 2 == 0));
      end
      if (i % 2 == 0) begin
        n_chk++;
        if (grant[2] !== (one << (i / 2))) begin
          n_fail++;
          $display("FAIL zgap_grant cyc %0d got %b want %b",
                   i, grant[2], one << (i / 2));
        end
      end
    end
    iValid = 1'b0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 600; t++) begin
      iValid = ($urandom_range(0, 3) != 0);
      iData  = 1'($urandom_range(0, 1));
      iReady = 4'($urandom);
      iEn    = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hf;
      tick();
      if ($urandom_range(0, 79) == 0) begin
        #1 iRST_N = 1'b0;
        model_reset();
        @(negedge iCLK);
        #2 iRST_N = 1'b1;
      end
    end
  endtask

  initial begin
    iValid = 1'b0; iData = 1'b0;
    iReady = 4'b0; iEn = 4'b0;
    model_reset();
    test_reset();
    test_single_channel();
    test_round_robin();
    test_stall();
    test_mask_abort();
    test_async_reset();
    test_zero_gap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
